// File: rtl/aurora_flow_ctrl_pkg.sv
// Shared types and NFC message encodings for the Aurora RX flow-control slice.
package aurora_flow_ctrl_pkg;

    localparam logic [15:0] NFC_XOFF = 16'h0100;
    localparam logic [15:0] NFC_XON  = 16'h0000;

    typedef enum logic [1:0] {
        ST_XON,
        ST_SEND_XOFF,
        ST_XOFF,
        ST_SEND_XON
    } nfc_state_t;

    typedef struct packed {
        logic         tlast;
        logic [31:0]  tkeep;
        logic [255:0] tdata;
    } rx_word_t;

endpackage

// File: rtl/aurora_rx_flow_ctrl_if.sv
// Stream-side signals of the RX flow controller: unbackpressured input,
// buffered output stream and the NFC request channel toward the core.
interface aurora_rx_flow_ctrl_if;

    logic [255:0] in_tdata;
    logic [31:0]  in_tkeep;
    logic         in_tlast;
    logic         in_tvalid;
    logic [255:0] out_tdata;
    logic [31:0]  out_tkeep;
    logic         out_tlast;
    logic         out_tvalid;
    logic         out_tready;
    logic         nfc_tvalid;
    logic [15:0]  nfc_tdata;
    logic         nfc_tready;

    modport master (
        output in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready, nfc_tready,
        input  out_tdata, out_tkeep, out_tlast, out_tvalid, nfc_tvalid, nfc_tdata
    );

    modport slave (
        input  in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready, nfc_tready,
        output out_tdata, out_tkeep, out_tlast, out_tvalid, nfc_tvalid, nfc_tdata
    );

endinterface

// File: rtl/aurora_rx_fifo_ram.sv
// Simple dual-port RAM with a registered read port; the read register doubles
// as the FIFO's output register, so it is reset to keep the stream outputs at 0.
module aurora_rx_fifo_ram #(
    parameter int unsigned WIDTH  = 289,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aurora_rx_flow_ctrl.sv
// Buffers the Aurora RX stream (which has no tready) into a FIFO and requests
// XOFF/XON from the link partner via Native Flow Control before it overflows.
module aurora_rx_flow_ctrl
    import aurora_flow_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_SIZE   = 9,
    parameter int unsigned XOFF_THRESH = 384,
    parameter int unsigned XON_THRESH  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 channel_up,
    aurora_rx_flow_ctrl_if.slave bus,
    output logic [FIFO_SIZE:0]   occupancy,
    output logic                 xoff_active,
    output logic                 overflow,
    output logic [31:0]          drop_count,
    input  logic                 clear_overflow
);

    localparam int unsigned DEPTH  = 2**FIFO_SIZE;
    localparam int unsigned PTR_W  = FIFO_SIZE;
    localparam int unsigned CNT_W  = FIFO_SIZE + 1;
    localparam int unsigned WORD_W = $bits(rx_word_t);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] XOFF_LVL = CNT_W'(XOFF_THRESH);
    localparam logic [CNT_W-1:0] XON_LVL  = CNT_W'(XON_THRESH);

    if (XON_THRESH >= XOFF_THRESH || XOFF_THRESH >= DEPTH) begin : g_param_check
        $error("aurora_rx_flow_ctrl: thresholds must satisfy XON_THRESH < XOFF_THRESH < 2**FIFO_SIZE");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ram_count_q, ram_count_d, occupancy_q, occupancy_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      drop_count_q, drop_count_d;
    nfc_state_t       nfc_state_q, nfc_state_d;

    logic             full, wr_en, rd_en, drop, pop;
    rx_word_t         in_word, out_word;
    logic [WORD_W-1:0] ram_rd_data;

    // Full is judged on the registered count, so a same-cycle pop never makes
    // room; the RAM read register is the output stage and is refilled whenever
    // it is empty or being consumed.
    always_comb begin
        full          = (ram_count_q == FULL_LVL);
        wr_en         = bus.in_tvalid && !full;
        drop          = bus.in_tvalid && full;
        pop           = out_valid_q && bus.out_tready;
        rd_en         = (ram_count_q != '0) && (!out_valid_q || bus.out_tready);
        in_word.tlast = bus.in_tlast;
        in_word.tkeep = bus.in_tkeep;
        in_word.tdata = bus.in_tdata;

        wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ram_count_d = ram_count_q;
        case ({wr_en, rd_en})
            2'b10:   ram_count_d = ram_count_q + CNT_W'(1);
            2'b01:   ram_count_d = ram_count_q - CNT_W'(1);
            default: ram_count_d = ram_count_q;
        endcase

        out_valid_d = out_valid_q;
        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        occupancy_d = ram_count_d + CNT_W'(out_valid_d);

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = clear_overflow ? 32'd1 :
                           (drop_count_q == '1) ? drop_count_q : drop_count_q + 32'd1;
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // Link-down drops straight to ST_XON without an XON message, since the
    // partner clears its own pause state when the channel goes down.
    always_comb begin
        nfc_state_d = nfc_state_q;
        if (!channel_up) begin
            nfc_state_d = ST_XON;
        end else begin
            case (nfc_state_q)
                ST_XON:       if (occupancy_q >= XOFF_LVL) nfc_state_d = ST_SEND_XOFF;
                ST_SEND_XOFF: if (bus.nfc_tready)          nfc_state_d = ST_XOFF;
                ST_XOFF:      if (occupancy_q <= XON_LVL)  nfc_state_d = ST_SEND_XON;
                ST_SEND_XON:  if (bus.nfc_tready)          nfc_state_d = ST_XON;
                default:                                   nfc_state_d = ST_XON;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            occupancy_q  <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            nfc_state_q  <= ST_XON;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            occupancy_q  <= occupancy_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            nfc_state_q  <= nfc_state_d;
        end
    end

    aurora_rx_fifo_ram #(
        .WIDTH  (WORD_W),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (in_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign out_word       = rx_word_t'(ram_rd_data);
    assign bus.out_tdata  = out_word.tdata;
    assign bus.out_tkeep  = out_word.tkeep;
    assign bus.out_tlast  = out_word.tlast;
    assign bus.out_tvalid = out_valid_q;

    assign bus.nfc_tvalid = (nfc_state_q == ST_SEND_XOFF) || (nfc_state_q == ST_SEND_XON);
    assign bus.nfc_tdata  = (nfc_state_q == ST_SEND_XOFF) ? NFC_XOFF : NFC_XON;
    assign xoff_active    = (nfc_state_q == ST_XOFF) || (nfc_state_q == ST_SEND_XON);

    assign occupancy  = occupancy_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_aurora_rx_flow_ctrl.sv
// Directed bench for aurora_rx_flow_ctrl: a scoreboard queue checks popped
// words in order while the main sequence checks latency, NFC and overflow.
module tb_aurora_rx_flow_ctrl;
    import aurora_flow_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        channel_up;
    logic        clear_overflow;
    logic [9:0]  occupancy;
    logic        xoff_active;
    logic        overflow;
    logic [31:0] drop_count;

    aurora_rx_flow_ctrl_if bus();

    aurora_rx_flow_ctrl #(
        .FIFO_SIZE   (9),
        .XOFF_THRESH (384),
        .XON_THRESH  (128)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .channel_up     (channel_up),
        .bus            (bus),
        .occupancy      (occupancy),
        .xoff_active    (xoff_active),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    rx_word_t    sb[$];
    int          nfc_hs = 0;
    logic [15:0] nfc_last = '0;
    bit          nfc_seen = 1'b0;

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [255:0] d, input logic [31:0] k, input logic l, input bit push);
        rx_word_t w;
        bus.in_tdata  = d;
        bus.in_tkeep  = k;
        bus.in_tlast  = l;
        bus.in_tvalid = 1'b1;
        w.tdata = d;
        w.tkeep = k;
        w.tlast = l;
        if (push) sb.push_back(w);
    endtask

    task automatic idleInputs();
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = '0;
        bus.in_tkeep  = '0;
        bus.in_tlast  = 1'b0;
    endtask

    function automatic logic [255:0] mkData(input int idx);
        logic [31:0] v;
        v = 32'(idx);
        return {v ^ 32'hDEAD_0000, {6{v ^ 32'h1234_5678}}, v};
    endfunction

    function automatic logic [31:0] mkKeep(input int idx);
        logic [31:0] v;
        v = 32'(idx);
        return 32'hFFFF_FFFF >> v[2:0];
    endfunction

    // Scoreboard pops and NFC handshake bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_tvalid && bus.out_tready) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("[TB] FAIL pop_unexpected: observed word %0h expected none", bus.out_tdata);
                end
                if (sb.size() != 0) begin
                    rx_word_t e;
                    e = sb.pop_front();
                    checkOutput("pop_word", 512'({bus.out_tlast, bus.out_tkeep, bus.out_tdata}), 512'(e));
                end
            end
            if (bus.nfc_tvalid) nfc_seen = 1'b1;
            if (bus.nfc_tvalid && bus.nfc_tready) begin
                nfc_hs++;
                nfc_last = bus.nfc_tdata;
            end
        end
    end

    initial begin
        int hs_before;
        bit hit;
        rst = 1'b1;
        channel_up = 1'b0;
        clear_overflow = 1'b0;
        bus.out_tready = 1'b0;
        bus.nfc_tready = 1'b0;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_out_tvalid", 512'(bus.out_tvalid), 512'(1'b0));
        checkOutput("rst_nfc_tvalid", 512'(bus.nfc_tvalid), 512'(1'b0));
        checkOutput("rst_occupancy", 512'(occupancy), 512'(10'd0));
        checkOutput("rst_overflow", 512'(overflow), 512'(1'b0));
        checkOutput("rst_drop_count", 512'(drop_count), 512'(32'd0));
        checkOutput("rst_xoff_active", 512'(xoff_active), 512'(1'b0));

        // 1: four-word packet through an empty FIFO
        $display("[TB] test 1: short packet latency");
        channel_up = 1'b1;
        bus.out_tready = 1'b1;
        nfc_seen = 1'b0;
        applyStimulus(256'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        checkOutput("t1_lat_n1", 512'(bus.out_tvalid), 512'(1'b0));
        applyStimulus(256'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        checkOutput("t1_lat_n2_valid", 512'(bus.out_tvalid), 512'(1'b1));
        checkOutput("t1_lat_n2_data", 512'(bus.out_tdata), 512'(256'd1));
        applyStimulus(256'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        applyStimulus(256'd4, 32'h0000_FFFF, 1'b1, 1'b1);
        tick();
        idleInputs();
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t1_sb_drained", 512'(sb.size()), 512'(0));
        checkOutput("t1_no_nfc", 512'(nfc_seen), 512'(1'b0));

        // 2: fill to the XOFF threshold with the output stalled
        $display("[TB] test 2: XOFF request");
        bus.out_tready = 1'b0;
        for (int i = 1; i <= 384; i++) begin
            applyStimulus(mkData(i), mkKeep(i), (i % 16) == 0, 1'b1);
            tick();
        end
        idleInputs();
        checkOutput("t2_occ_384", 512'(occupancy), 512'(10'd384));
        checkOutput("t2_nfc_not_yet", 512'(bus.nfc_tvalid), 512'(1'b0));
        tick();
        checkOutput("t2_nfc_tvalid", 512'(bus.nfc_tvalid), 512'(1'b1));
        checkOutput("t2_nfc_tdata", 512'(bus.nfc_tdata), 512'(16'h0100));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t2_hold_tvalid", 512'(bus.nfc_tvalid), 512'(1'b1));
            checkOutput("t2_hold_tdata", 512'(bus.nfc_tdata), 512'(16'h0100));
        end
        bus.nfc_tready = 1'b1;
        tick();
        bus.nfc_tready = 1'b0;
        checkOutput("t2_xoff_active", 512'(xoff_active), 512'(1'b1));
        checkOutput("t2_nfc_done", 512'(bus.nfc_tvalid), 512'(1'b0));
        checkOutput("t2_hs_data", 512'(nfc_last), 512'(16'h0100));

        // 3: drain and expect exactly one XON at occupancy 128
        $display("[TB] test 3: drain and XON");
        nfc_hs = 0;
        bus.out_tready = 1'b1;
        bus.nfc_tready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            if (occupancy <= 10'd128) hit = 1'b1;
        end
        checkOutput("t3_reached_xon_lvl", 512'(hit), 512'(1'b1));
        checkOutput("t3_occ_128", 512'(occupancy), 512'(10'd128));
        checkOutput("t3_nfc_not_yet", 512'(bus.nfc_tvalid), 512'(1'b0));
        tick();
        checkOutput("t3_xon_tvalid", 512'(bus.nfc_tvalid), 512'(1'b1));
        checkOutput("t3_xon_tdata", 512'(bus.nfc_tdata), 512'(16'h0000));
        checkOutput("t3_xoff_still", 512'(xoff_active), 512'(1'b1));
        tick();
        checkOutput("t3_xoff_cleared", 512'(xoff_active), 512'(1'b0));
        checkOutput("t3_nfc_idle", 512'(bus.nfc_tvalid), 512'(1'b0));
        for (int i = 0; i < 300 && (sb.size() != 0 || bus.out_tvalid); i++) tick();
        checkOutput("t3_sb_drained", 512'(sb.size()), 512'(0));
        checkOutput("t3_occ_empty", 512'(occupancy), 512'(10'd0));
        checkOutput("t3_single_xon", 512'(nfc_hs), 512'(1));
        checkOutput("t3_xon_value", 512'(nfc_last), 512'(16'h0000));

        // 4: overflow with the output stalled
        $display("[TB] test 4: overflow");
        bus.out_tready = 1'b0;
        for (int i = 1; i <= 514; i++) begin
            applyStimulus(mkData(1000 + i), mkKeep(i), (i % 8) == 0, i <= 513);
            tick();
            if (i == 513) checkOutput("t4_no_ovf_yet", 512'(overflow), 512'(1'b0));
        end
        idleInputs();
        checkOutput("t4_occ_513", 512'(occupancy), 512'(10'd513));
        checkOutput("t4_overflow", 512'(overflow), 512'(1'b1));
        checkOutput("t4_drop_count", 512'(drop_count), 512'(32'd1));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checkOutput("t4_clr_overflow", 512'(overflow), 512'(1'b0));
        checkOutput("t4_clr_drop_count", 512'(drop_count), 512'(32'd0));
        applyStimulus(mkData(9999), 32'hFFFF_FFFF, 1'b1, 1'b0);
        clear_overflow = 1'b1;
        tick();
        idleInputs();
        clear_overflow = 1'b0;
        checkOutput("t4_drop_wins_ovf", 512'(overflow), 512'(1'b1));
        checkOutput("t4_drop_wins_cnt", 512'(drop_count), 512'(32'd1));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checkOutput("t4_clr2_drop_count", 512'(drop_count), 512'(32'd0));
        checkOutput("t4_xoff_active", 512'(xoff_active), 512'(1'b1));

        // 5: channel drop while paused
        $display("[TB] test 5: channel drop");
        hs_before = nfc_hs;
        channel_up = 1'b0;
        tick();
        channel_up = 1'b1;
        checkOutput("t5_xoff_cleared", 512'(xoff_active), 512'(1'b0));
        checkOutput("t5_no_nfc", 512'(bus.nfc_tvalid), 512'(1'b0));
        checkOutput("t5_no_hs", 512'(nfc_hs), 512'(hs_before));
        checkOutput("t5_occ_kept", 512'(occupancy), 512'(10'd513));

        // 6: reset mid-packet, then a fresh packet
        $display("[TB] test 6: reset mid-packet");
        bus.out_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(mkData(7777), 32'hFFFF_FFFF, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idleInputs();
        sb.delete();
        checkOutput("t6_out_tvalid", 512'(bus.out_tvalid), 512'(1'b0));
        checkOutput("t6_out_word", 512'({bus.out_tlast, bus.out_tkeep, bus.out_tdata}), 512'(0));
        checkOutput("t6_nfc", 512'({bus.nfc_tvalid, bus.nfc_tdata}), 512'(0));
        checkOutput("t6_occupancy", 512'(occupancy), 512'(10'd0));
        checkOutput("t6_status", 512'({xoff_active, overflow, drop_count}), 512'(0));
        applyStimulus(mkData(42), 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        checkOutput("t6_lat_n1", 512'(bus.out_tvalid), 512'(1'b0));
        applyStimulus(mkData(43), 32'h0000_00FF, 1'b1, 1'b1);
        tick();
        idleInputs();
        checkOutput("t6_lat_n2", 512'(bus.out_tvalid), 512'(1'b1));
        checkOutput("t6_first_data", 512'(bus.out_tdata), 512'(mkData(42)));
        tick();
        tick();
        checkOutput("t6_sb_drained", 512'(sb.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
